// File: rtl/reg32_wr_arbiter_pkg.sv
// Shared types and constants for the round-robin write arbiter in front of a
// load-enabled storage register.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);
  localparam int WCNT_W      = 16;
  localparam int HOLD_W      = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg32_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester set when scanning
// upward from the one after i_rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic               o_any,
  output logic [ID_W-1:0]    o_winner
);

  int   w_idx;
  logic w_hit;

  // Scan priority order; the first hit locks the winner.
  always_comb begin
    o_any    = 1'b0;
    o_winner = '0;
    w_idx    = 0;
    w_hit    = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx    = int'(i_rr_ptr) + i;
      w_idx    = (w_idx >= NUM_REQ) ? (w_idx - NUM_REQ) : w_idx;
      w_hit    = !o_any && i_req[w_idx];
      o_winner = w_hit ? w_idx[ID_W-1:0] : o_winner;
      o_any    = o_any | w_hit;
    end
  end

endmodule

// File: rtl/reg32_wr_arbiter.sv
// Round-robin arbiter sharing one load-enabled storage register among
// NUM_REQ writers, with one-cycle-later readback check of every write.
module reg32_wr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 32,
  parameter int HOLD_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       load,
  output logic [WIDTH-1:0]           d,
  input  logic [WIDTH-1:0]           q,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [WCNT_W-1:0]          wr_count,
  output logic                       err
);

  localparam int                 ID_W      = id_width(NUM_REQ);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_grant_id;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [NUM_REQ-1:0] r_req_ready;
  logic               r_load;
  logic [WIDTH-1:0]   r_d;
  logic               r_busy;
  logic [WCNT_W-1:0]  r_wr_count;
  logic               r_err;
  logic               w_any;
  logic [ID_W-1:0]    w_winner;
  logic [WIDTH-1:0]   w_sel_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req    (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  // Mux out the winning requester's data word.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_data = (w_winner == ID_W'(i)) ? req_data[i*WIDTH +: WIDTH] : w_sel_data;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_any ? ISSUE : IDLE;
      ISSUE:   w_state_nxt = CHECK;
      CHECK:   w_state_nxt = (HOLD_CYCLES > 0) ? HOLD : IDLE;
      HOLD:    w_state_nxt = (r_hold_cnt <= 4'd1) ? IDLE : HOLD;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs, pointer, hold counter and readback check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= ID_W'(NUM_REQ - 1);
      r_grant_id  <= '0;
      r_hold_cnt  <= '0;
      r_req_ready <= '0;
      r_load      <= 1'b0;
      r_d         <= '0;
      r_busy      <= 1'b0;
      r_wr_count  <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_d         <= w_sel_data;
            r_load      <= 1'b1;
            r_req_ready <= ONE_HOT0 << w_winner;
            r_grant_id  <= w_winner;
            r_rr_ptr    <= w_winner;
          end
        end
        ISSUE: begin
          r_load      <= 1'b0;
          r_req_ready <= '0;
          r_wr_count  <= r_wr_count + 16'd1;
        end
        CHECK: begin
          if (q != r_d) begin
            r_err <= 1'b1;
          end
          r_hold_cnt <= HOLD_LOAD;
        end
        HOLD: begin
          r_hold_cnt <= r_hold_cnt - 4'd1;
        end
        default: begin
          r_load      <= 1'b0;
          r_req_ready <= '0;
        end
      endcase
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  assign req_ready = r_req_ready;
  assign load      = r_load;
  assign d         = r_d;
  assign grant_id  = r_grant_id;
  assign busy      = r_busy;
  assign wr_count  = r_wr_count;
  assign err       = r_err;

endmodule

// File: tb/tb_reg32_wr_arbiter.sv
// Scoreboard bench: two arbiters (HOLD_CYCLES 0 and 4), each in front of a
// behavioural storage register; expected grants are queued as stimulus is issued.
module tb_reg32_wr_arbiter;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid0, req_valid1, req_ready0, req_ready1;
  logic [127:0] req_data0, req_data1;
  logic         load0, load1, busy0, busy1, err0, err1;
  logic [31:0]  d0, d1, q0, q1, q_reg0, q_reg1;
  logic [1:0]   gid0, gid1;
  logic [15:0]  wrc0, wrc1;

  exp_t         expq [2][$];
  logic [31:0]  rq [8][$];
  int           cyc = 0;
  int           last_load [2];
  int           gap_exp [2];
  int           cnt [2];
  logic         pend_q [2];
  logic [31:0]  pend_d [2];
  int           force_cnt = 0;
  bit           force_arm = 1'b0;
  bit           rst_at_load = 1'b0;
  int           n_tests = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural storage registers; q0 can be forced to zero to plant a fault.
  always_ff @(posedge clk) begin
    if (load0) q_reg0 <= d0;
    if (load1) q_reg1 <= d1;
  end
  assign q0 = (force_cnt != 0) ? 32'h0 : q_reg0;
  assign q1 = q_reg1;

  reg32_wr_arbiter #(.NUM_REQ(4), .WIDTH(32), .HOLD_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_data(req_data0),
    .req_ready(req_ready0), .load(load0), .d(d0), .q(q0), .grant_id(gid0),
    .busy(busy0), .wr_count(wrc0), .err(err0)
  );

  reg32_wr_arbiter #(.NUM_REQ(4), .WIDTH(32), .HOLD_CYCLES(4)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_data(req_data1),
    .req_ready(req_ready1), .load(load1), .d(d1), .q(q1), .grant_id(gid1),
    .busy(busy1), .wr_count(wrc1), .err(err1)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_idle_outs(input int k, input string why);
    chk_eq($sformatf("%s_load%0d", why, k),  32'((k == 0) ? load0 : load1), 32'd0);
    chk_eq($sformatf("%s_ready%0d", why, k), 32'((k == 0) ? req_ready0 : req_ready1), 32'd0);
    chk_eq($sformatf("%s_d%0d", why, k),     (k == 0) ? d0 : d1, 32'd0);
    chk_eq($sformatf("%s_gid%0d", why, k),   32'((k == 0) ? gid0 : gid1), 32'd0);
    chk_eq($sformatf("%s_wrc%0d", why, k),   32'((k == 0) ? wrc0 : wrc1), 32'd0);
    chk_eq($sformatf("%s_err%0d", why, k),   32'((k == 0) ? err0 : err1), 32'd0);
    chk_eq($sformatf("%s_busy%0d", why, k),  32'((k == 0) ? busy0 : busy1), 32'd0);
  endtask

  task automatic clear_model(input int k);
    cnt[k]       = 0;
    pend_q[k]    = 1'b0;
    last_load[k] = -1;
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        logic        v;
        logic [31:0] w;
        v = (rq[k*4+i].size() > 0);
        w = v ? rq[k*4+i][0] : 32'h0;
        if (k == 0) begin
          req_valid0[i] = v;
          req_data0[i*32 +: 32] = w;
        end else begin
          req_valid1[i] = v;
          req_data1[i*32 +: 32] = w;
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      logic        ld;
      logic        bz;
      logic [31:0] dd, qq;
      logic [3:0]  rr;
      logic [1:0]  gg;
      logic [15:0] ww;
      ld = (k == 0) ? load0 : load1;
      bz = (k == 0) ? busy0 : busy1;
      dd = (k == 0) ? d0 : d1;
      qq = (k == 0) ? q0 : q1;
      rr = (k == 0) ? req_ready0 : req_ready1;
      gg = (k == 0) ? gid0 : gid1;
      ww = (k == 0) ? wrc0 : wrc1;
      if (pend_q[k]) begin
        if (!(k == 0 && force_cnt != 0)) chk_eq($sformatf("q%0d", k), qq, pend_d[k]);
        chk_eq($sformatf("wr_count%0d", k), 32'(ww), 32'(cnt[k]));
        pend_q[k] = 1'b0;
      end
      if (ld) begin
        if (expq[k].size() == 0) begin
          chk_eq($sformatf("unexpected_load%0d", k), 32'(ld), 32'd0);
        end else begin
          e = expq[k].pop_front();
          chk_eq($sformatf("d%0d", k), dd, e.data);
          chk_eq($sformatf("grant_id%0d", k), 32'(gg), 32'(e.id));
          chk_eq($sformatf("ready%0d", k), 32'(rr), 32'(4'b0001 << e.id));
          if (gap_exp[k] != 0 && last_load[k] >= 0)
            chk_eq($sformatf("gap%0d", k), 32'(cyc - last_load[k]), 32'(gap_exp[k]));
          last_load[k] = cyc;
          cnt[k]++;
          pend_q[k] = 1'b1;
          pend_d[k] = e.data;
          if (k == 0 && force_arm) begin
            force_cnt = 2;
            force_arm = 1'b0;
          end
        end
      end
      if (last_load[k] >= 0 && (cyc - last_load[k]) <= ((k == 0) ? 1 : 5))
        chk_eq($sformatf("busy%0d", k), 32'(bz), 32'd1);
    end
  endtask

  task automatic step();
    logic [3:0] hs0, hs1;
    @(negedge clk);
    monitor();
    if (rst_at_load && load0) begin
      rst = 1'b1;
      #1;
      check_idle_outs(0, "midrst");
      clear_model(0);
      rst_at_load = 1'b0;
    end
    hs0 = req_valid0 & req_ready0;
    hs1 = req_valid1 & req_ready1;
    @(posedge clk);
    cyc++;
    #1;
    if (force_cnt > 0) force_cnt--;
    for (int i = 0; i < 4; i++) begin
      if (hs0[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (hs1[i] && rq[4+i].size() > 0) void'(rq[4+i].pop_front());
    end
    drive_reqs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_idle_outs(0, "rst");
    check_idle_outs(1, "rst");
    clear_model(0);
    clear_model(1);
    force_cnt = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic int pending();
    int s;
    s = expq[0].size() + expq[1].size();
    for (int i = 0; i < 8; i++) s += rq[i].size();
    return s;
  endfunction

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    if (pending() != 0) chk_eq("timeout", 32'(pending()), 32'd0);
    repeat (3) step();
  endtask

  task automatic push_req(input int k, input int id, input logic [31:0] data);
    rq[k*4+id].push_back(data);
    expq[k].push_back(exp_t'{id: 2'(id), data: data});
  endtask

  initial begin
    rst = 1'b1;
    req_valid0 = 4'b0; req_valid1 = 4'b0;
    req_data0 = 128'h0; req_data1 = 128'h0;
    gap_exp[0] = 0; gap_exp[1] = 0;
    clear_model(0);
    clear_model(1);
    #2;
    do_reset();

    // Single write after reset.
    push_req(0, 0, 32'hA5A5A5A5);
    drive_reqs();
    run_until_done(20);
    chk_eq("single_wrc", 32'(wrc0), 32'd1);
    chk_eq("single_err", 32'(err0), 32'd0);

    // Four-way contention from a fresh pointer: order 0,1,2,3, 3 cycles apart.
    do_reset();
    gap_exp[0] = 3;
    push_req(0, 0, 32'h11111111);
    push_req(0, 1, 32'h22222222);
    push_req(0, 2, 32'h33333333);
    push_req(0, 3, 32'h44444444);
    drive_reqs();
    run_until_done(40);
    chk_eq("contend_wrc", 32'(wrc0), 32'd4);

    // Requesters 1 and 3 continuously valid: grants alternate 1,3,1,3,1,3.
    last_load[0] = -1;
    for (int j = 0; j < 3; j++) begin
      push_req(0, 1, 32'h1000_0000 + 32'(j));
      push_req(0, 3, 32'h3000_0000 + 32'(j));
    end
    drive_reqs();
    run_until_done(60);
    chk_eq("fair_wrc", 32'(wrc0), 32'd10);
    gap_exp[0] = 0;

    // Readback fault: err sets and stays set over later good writes.
    do_reset();
    force_arm = 1'b1;
    push_req(0, 0, 32'hDEADBEEF);
    drive_reqs();
    run_until_done(20);
    chk_eq("fault_err", 32'(err0), 32'd1);
    push_req(0, 2, 32'h0000_0001);
    push_req(0, 3, 32'h0000_0002);
    drive_reqs();
    run_until_done(30);
    chk_eq("fault_err_sticky", 32'(err0), 32'd1);
    chk_eq("fault_wrc", 32'(wrc0), 32'd3);
    do_reset();

    // HOLD_CYCLES=4: back-to-back writes from requester 2, loads 7 cycles apart.
    gap_exp[1] = 7;
    push_req(1, 2, 32'h12345678);
    push_req(1, 2, 32'h87654321);
    drive_reqs();
    run_until_done(40);
    chk_eq("hold_wrc", 32'(wrc1), 32'd2);
    chk_eq("hold_err", 32'(err1), 32'd0);
    gap_exp[1] = 0;

    // Reset during ISSUE: write dropped, requester 1 re-granted afterwards.
    push_req(0, 1, 32'hCAFE0001);
    expq[0].push_back(exp_t'{id: 2'd1, data: 32'hCAFE0001});
    drive_reqs();
    rst_at_load = 1'b1;
    for (int n = 0; n < 20 && rst !== 1'b1; n++) step();
    chk_eq("midrst_hit", 32'(rst), 32'd1);
    rst_at_load = 1'b0;
    step();
    rst = 1'b0;
    run_until_done(20);
    chk_eq("midrst_wrc", 32'(wrc0), 32'd1);
    chk_eq("midrst_q", q_reg0, 32'hCAFE0001);
    chk_eq("midrst_gid", 32'(gid0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
